alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request strobe, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 req_a  input  2x32  packed operand A per requester.
REQ-007 req_b  input  2x32  packed operand B per requester.
REQ-008 req_op  input  2x3  ALU op per requester: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-009 rsp_valid  output  2  per-requester response strobe; at most one bit high.
REQ-010 rsp_ready  input  2  per-requester response accept.
REQ-011 rsp_result  output  32  result, meaningful only while a rsp_valid bit is high.
REQ-012 rsp_zero  output  1  captured ALU zero flag.
REQ-013 rsp_err  output  1  illegal op code flag.
REQ-014 alu_srcA, alu_srcB  output  32 each  drive to shared ALU.
REQ-015 alu_cntrl  output  3  drive to shared ALU.
REQ-016 alu_out  input  32; alu_zero  input  1  combinational ALU return.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and RESP; reset state IDLE.
REQ-019 Handshake SHALL be: request transfer when req_valid[i] && req_ready[i]; response transfer when rsp_valid[i] && rsp_ready[i].
REQ-020 req_ready SHALL be combinational and SHALL be high only in IDLE, only for the granted requester, and only while that requester's req_valid is high.
REQ-021 Arbitration SHALL be round-robin: with a single valid requester, grant it; with both valid, grant the one not most recently accepted.
REQ-022 The last-grant pointer SHALL reset to 1, so requester 0 wins the first simultaneous request.
REQ-023 The last-grant pointer SHALL update only on request transfer.
REQ-024 On request transfer, the block SHALL latch a, b, op and requester id.
REQ-025 IDLE SHALL go to EXEC when op is legal, and to RESP when op is illegal (100, 110, 111).
REQ-026 In EXEC, alu_srcA, alu_srcB and alu_cntrl SHALL come from the latched values.
REQ-027 At the end of EXEC, alu_out and alu_zero SHALL be registered into rsp_result and rsp_zero, and the FSM SHALL go to RESP.
REQ-028 Illegal op response SHALL be rsp_result=0, rsp_zero=0, rsp_err=1.
REQ-029 Legal op response SHALL have rsp_err=0.
REQ-030 In RESP, rsp_valid[id]=1; rsp_result, rsp_zero and rsp_err SHALL be held stable until transfer.
REQ-031 On response transfer, the FSM SHALL return to IDLE.
REQ-032 A new request SHALL NOT be accepted in the cycle of response transfer; the earliest next accept is the following cycle.
REQ-033 Latency SHALL be: request transfer in cycle N gives rsp_valid in cycle N+2 for a legal op and N+1 for an illegal op.
REQ-034 Maximum throughput SHALL be one operation per 3 cycles (2 for an illegal op).
REQ-035 Outside EXEC, the ALU drive outputs SHALL hold their last latched values and SHALL NOT toggle.
REQ-036 Requesters SHALL hold req_a, req_b and req_op stable while req_valid is high and req_ready is low.
REQ-037 Requesters MAY drop req_valid before grant; an ungranted request SHALL have no effect.
REQ-038 rsp_ready on the non-addressed bit SHALL be ignored.
REQ-039 slt SHALL be the ALU's sign of (a-b) result and SHALL be passed through unmodified; the block SHALL NOT perform arithmetic.

Reset
REQ-040 Reset SHALL take effect at the next edge from any state.
REQ-041 Reset SHALL force: state IDLE; req_ready=0 for that cycle; rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0; alu_srcA=0, alu_srcB=0, alu_cntrl=000; busy=0; pointer=1.
REQ-042 A transaction in flight at reset SHALL be discarded without a response.

Verification
REQ-043 Reset held 2 cycles, then released -> all outputs 0 and busy=0 in the first post-reset cycle.
REQ-044 req0 a=5 b=3 op=000 accepted cycle 0 -> alu_cntrl=000 in cycle 1; rsp_valid=01, rsp_result=8, rsp_zero=0 in cycle 2.
REQ-045 Both requesters valid: req0 7-7 op=001, req1 0xF0|0x0F op=011 -> req0 served first (result 0, zero=1); req1 accepted the cycle after req0's response transfer (result 0xFF); then both valid again -> req0 granted.
REQ-046 req1 a=0xFFFFFFFF b=1 op=101 with rsp_ready low 5 cycles -> rsp_valid=10, result=1 held stable; req_ready=00 and busy=1 throughout.
REQ-047 req0 op=111 -> rsp_valid at N+1 with err=1, result=0, zero=0; ALU outputs unchanged.
REQ-048 Reset asserted during RESP -> rsp_valid=00 next cycle; no response is delivered.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external combinational ALU.
// One operation in flight at a time: IDLE accepts, EXEC drives the ALU, RESP holds the answer.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_srcA,
  output logic [WIDTH-1:0]   alu_srcB,
  output logic [2:0]         alu_cntrl,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic               last_q;
  logic               id_q;
  logic [WIDTH-1:0]   src_a_q, src_b_q;
  logic [2:0]         cntrl_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q, err_q;

  logic               grant;
  logic [2:0]         gnt_op;
  logic               op_illegal;
  logic               accept;
  logic               rsp_fire;

  always_comb begin
    grant      = 1'b0;
    gnt_op     = 3'b000;
    op_illegal = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    state_d    = state_q;

    // Both requesting: favour the one not accepted last
    if (req_valid == 2'b11) begin
      grant = ~last_q;
    end else begin
      grant = req_valid[1];
    end
    gnt_op     = grant ? req_op[5:3] : req_op[2:0];
    op_illegal = gnt_op[2] & (gnt_op != 3'b101);
    accept     = (state_q == StIdle) & req_valid[grant] & ~reset;

    if (accept) begin
      req_ready[grant] = 1'b1;
    end
    if (state_q == StResp) begin
      rsp_valid[id_q] = 1'b1;
      rsp_fire        = rsp_ready[id_q];
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = op_illegal ? StResp : StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (rsp_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      cntrl_q  <= 3'b000;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= grant;
        id_q   <= grant;
        // Illegal ops never reach the ALU, so its drive registers are left untouched
        if (op_illegal) begin
          result_q <= '0;
          zero_q   <= 1'b0;
          err_q    <= 1'b1;
        end else begin
          src_a_q <= grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          src_b_q <= grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          cntrl_q <= gnt_op;
        end
      end
      if (state_q == StExec) begin
        result_q <= alu_out;
        zero_q   <= alu_zero;
        err_q    <= 1'b0;
      end
    end
  end

  assign alu_srcA   = src_a_q;
  assign alu_srcB   = src_b_q;
  assign alu_cntrl  = cntrl_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [5:0]  req_op;
  logic [31:0] rsp_result, alu_srcA, alu_srcB, alu_out;
  logic        rsp_zero, rsp_err, alu_zero, busy;
  logic [2:0]  alu_cntrl;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_cntrl  (alu_cntrl),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [31:0] d;
    d = a - b;
    case (op)
      3'b000:  return a + b;
      3'b001:  return d;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {31'b0, d[31]};
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_out  = alu_f(alu_srcA, alu_srcB, alu_cntrl);
    alu_zero = (alu_out == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_op[idx*3 +: 3]  = op;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nx();
    nx();
    reset = 1'b0;
    nx();
  endtask

  task automatic wait_rsp(input int idx, input int maxc);
    int n;
    n = 0;
    while (!rsp_valid[idx] && n < maxc) begin
      nx();
      n++;
    end
    chk("rsp_timeout", {31'b0, rsp_valid[idx]}, 32'd1);
  endtask

  // Scoreboard: push on request transfer, pop and compare on response transfer
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", {30'b0, rsp_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_id", {31'b0, rsp_valid[1]}, {31'b0, mon_e.id});
          chk("sb_result", rsp_result, mon_e.res);
          chk("sb_zero", {31'b0, rsp_zero}, {31'b0, mon_e.zero});
          chk("sb_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_e.id = i[0];
          if (req_op[i*3 +: 3] inside {3'b100, 3'b110, 3'b111}) begin
            mon_e.res  = 32'h0;
            mon_e.zero = 1'b0;
            mon_e.err  = 1'b1;
          end else begin
            mon_e.res  = alu_f(req_a[i*32 +: 32], req_b[i*32 +: 32], req_op[i*3 +: 3]);
            mon_e.zero = (mon_e.res == 32'h0);
            mon_e.err  = 1'b0;
          end
          sb.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b00;
    nx();
    nx();
    reset = 1'b0;
    nx();
    // Post-reset state
    chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {30'b0, rsp_zero, rsp_err}, 32'd0);
    chk("rst_srca", alu_srcA, 32'd0);
    chk("rst_srcb", alu_srcB, 32'd0);
    chk("rst_cntrl", {29'b0, alu_cntrl}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Single add from requester 0
    set_req(0, 32'd5, 32'd3, 3'b000);
    req_valid = 2'b01;
    #1 chk("add_req_ready", {30'b0, req_ready}, 32'd1);
    nx();
    req_valid = 2'b00;
    chk("add_exec_busy", {31'b0, busy}, 32'd1);
    chk("add_exec_cntrl", {29'b0, alu_cntrl}, 32'd0);
    chk("add_exec_srca", alu_srcA, 32'd5);
    chk("add_exec_srcb", alu_srcB, 32'd3);
    chk("add_exec_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    nx();
    chk("add_rsp_valid", {30'b0, rsp_valid}, 32'd1);
    chk("add_rsp_result", rsp_result, 32'd8);
    chk("add_rsp_zero", {31'b0, rsp_zero}, 32'd0);
    chk("add_rsp_err", {31'b0, rsp_err}, 32'd0);
    rsp_ready = 2'b01;
    nx();
    rsp_ready = 2'b00;
    chk("add_done_busy", {31'b0, busy}, 32'd0);
    chk("add_done_rsp_valid", {30'b0, rsp_valid}, 32'd0);

    // Contention after reset: requester 0 wins first
    do_reset();
    set_req(0, 32'd7, 32'd7, 3'b001);
    set_req(1, 32'hF0, 32'h0F, 3'b011);
    req_valid = 2'b11;
    #1 chk("rr_first_grant", {30'b0, req_ready}, 32'd1);
    nx();
    req_valid = 2'b10;
    #1 chk("rr_exec_req_ready", {30'b0, req_ready}, 32'd0);
    nx();
    chk("rr_rsp0_valid", {30'b0, rsp_valid}, 32'd1);
    chk("rr_rsp0_result", rsp_result, 32'd0);
    chk("rr_rsp0_zero", {31'b0, rsp_zero}, 32'd1);
    chk("rr_resp_req_ready", {30'b0, req_ready}, 32'd0);
    rsp_ready = 2'b11;
    nx();
    chk("rr_req1_ready", {30'b0, req_ready}, 32'd2);
    chk("rr_idle_busy", {31'b0, busy}, 32'd0);
    nx();
    req_valid = 2'b00;
    chk("rr_req1_exec_busy", {31'b0, busy}, 32'd1);
    chk("rr_req1_cntrl", {29'b0, alu_cntrl}, 32'd3);
    nx();
    chk("rr_rsp1_valid", {30'b0, rsp_valid}, 32'd2);
    chk("rr_rsp1_result", rsp_result, 32'hFF);
    nx();
    set_req(0, 32'h10, 32'h20, 3'b000);
    set_req(1, 32'd1, 32'd1, 3'b000);
    req_valid = 2'b11;
    #1 chk("rr_second_grant", {30'b0, req_ready}, 32'd1);
    nx();
    req_valid = 2'b00;
    wait_rsp(0, 5);
    nx();
    rsp_ready = 2'b00;

    // slt with back-pressure; stray rsp_ready on the other bit is ignored
    set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b101);
    req_valid = 2'b10;
    nx();
    set_req(0, 32'd2, 32'd2, 3'b000);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      nx();
      chk("hold_rsp_valid", {30'b0, rsp_valid}, 32'd2);
      chk("hold_rsp_result", rsp_result, 32'd1);
      chk("hold_req_ready", {30'b0, req_ready}, 32'd0);
      chk("hold_busy", {31'b0, busy}, 32'd1);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    nx();
    rsp_ready = 2'b00;
    chk("hold_done_busy", {31'b0, busy}, 32'd0);

    // Illegal op: immediate error response, ALU drive untouched
    set_req(0, 32'd9, 32'd9, 3'b111);
    req_valid = 2'b01;
    #1 chk("ill_req_ready", {30'b0, req_ready}, 32'd1);
    nx();
    req_valid = 2'b00;
    chk("ill_rsp_valid", {30'b0, rsp_valid}, 32'd1);
    chk("ill_rsp_err", {31'b0, rsp_err}, 32'd1);
    chk("ill_rsp_result", rsp_result, 32'd0);
    chk("ill_rsp_zero", {31'b0, rsp_zero}, 32'd0);
    chk("ill_cntrl", {29'b0, alu_cntrl}, 32'd5);
    chk("ill_srca", alu_srcA, 32'hFFFF_FFFF);
    chk("ill_srcb", alu_srcB, 32'd1);
    rsp_ready = 2'b01;
    nx();
    rsp_ready = 2'b00;
    chk("ill_done_busy", {31'b0, busy}, 32'd0);

    // Reset while a response is pending discards it
    set_req(1, 32'hF, 32'd3, 3'b010);
    req_valid = 2'b10;
    nx();
    req_valid = 2'b00;
    nx();
    chk("rr_pre_reset_valid", {30'b0, rsp_valid}, 32'd2);
    chk("rr_pre_reset_result", rsp_result, 32'd3);
    reset = 1'b1;
    nx();
    reset = 1'b0;
    chk("rstresp_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("rstresp_busy", {31'b0, busy}, 32'd0);
    chk("rstresp_result", rsp_result, 32'd0);
    chk("rstresp_cntrl", {29'b0, alu_cntrl}, 32'd0);
    chk("rstresp_srca", alu_srcA, 32'd0);
    rsp_ready = 2'b11;
    nx();
    nx();
    chk("rstresp_no_rsp", {30'b0, rsp_valid}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
